// File: rtl/uart_ram_loader.sv
// Serial program loader: receives a framed 8N1 image and writes it into the
// 16-byte program RAM over the shared system bus while holding the CPU.
module uart_ram_loader #(
  parameter int          CLKS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mar_wr,
  output logic       ram_wr,
  output logic       cpu_hold,
  output logic       cpu_rst_req,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {HUNT, LEN, DATA, WR_ADDR, WR_DATA, CSUM, FINISH} fr_state_t;

  // rx_prev is one stage behind rx_s so a falling edge can be detected.
  logic rx_meta, rx_s, rx_prev;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             byte_valid, byte_valid_n;
  logic             frame_err, frame_err_n;
  logic [7:0]       byte_data;

  assign byte_data = rx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_BITS;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_BITS: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n     = '0;
          rx_state_n   = RX_IDLE;
          byte_valid_n = rx_s;
          frame_err_n  = !rx_s;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  fr_state_t  state, state_n;
  logic [3:0] addr, addr_n;
  logic [4:0] remaining, remaining_n;
  logic [7:0] sum, sum_n;
  logic [7:0] latch, latch_n;
  logic       done_n, err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      addr      <= '0;
      remaining <= '0;
      sum       <= '0;
      latch     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      sum       <= sum_n;
      latch     <= latch_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  // The CPU is held for exactly the in-frame states; FINISH already releases it.
  assign busy     = state inside {LEN, DATA, WR_ADDR, WR_DATA, CSUM};
  assign cpu_hold = busy;

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    sum_n       = sum;
    latch_n     = latch;
    done_n      = done;
    err_n       = err;
    bus_out     = 8'h00;
    bus_oe      = 1'b0;
    mar_wr      = 1'b0;
    ram_wr      = 1'b0;
    cpu_rst_req = 1'b0;
    case (state)
      HUNT: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_n = LEN;
          done_n  = 1'b0;
          err_n   = 1'b0;
          addr_n  = '0;
          sum_n   = '0;
        end
      end
      LEN: begin
        if (byte_valid) begin
          if (byte_data != 8'd0 && byte_data <= 8'd16) begin
            remaining_n = byte_data[4:0];
            state_n     = DATA;
          end else begin
            err_n   = 1'b1;
            state_n = HUNT;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
          latch_n = byte_data;
          sum_n   = sum + byte_data;
          state_n = WR_ADDR;
        end
      end
      WR_ADDR: begin
        bus_oe  = 1'b1;
        bus_out = {4'b0000, addr};
        mar_wr  = 1'b1;
        state_n = WR_DATA;
      end
      WR_DATA: begin
        bus_oe      = 1'b1;
        bus_out     = latch;
        ram_wr      = 1'b1;
        addr_n      = addr + 1'b1;
        remaining_n = remaining - 1'b1;
        state_n     = (remaining == 5'd1) ? CSUM : DATA;
      end
      CSUM: begin
        if (byte_valid) begin
          done_n  = (byte_data == sum);
          err_n   = (byte_data != sum);
          state_n = FINISH;
        end
      end
      FINISH: begin
        cpu_rst_req = done;
        state_n     = HUNT;
      end
      default: state_n = HUNT;
    endcase
    if (frame_err && state != HUNT) begin
      err_n   = 1'b1;
      state_n = HUNT;
    end
  end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized scoreboard bench for uart_ram_loader: a frame-level model queues
// expected bus writes and frame outcomes; a negedge monitor consumes them.
module tb_uart_ram_loader;
  localparam int         CPB  = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] bus_out;
  logic       bus_oe, mar_wr, ram_wr, cpu_hold, cpu_rst_req, busy, done, err;

  uart_ram_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus_out(bus_out), .bus_oe(bus_oe),
    .mar_wr(mar_wr), .ram_wr(ram_wr), .cpu_hold(cpu_hold),
    .cpu_rst_req(cpu_rst_req), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic done; logic err; } out_t;
  typedef logic [7:0] byte_q_t[$];

  wr_t  exp_wr[$];
  out_t exp_out[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_wr.size() + exp_out.size(), 0);
  endtask

  // Frame-level model: skip noise before the sync byte, then derive writes
  // and the outcome from the length and byte-sum rules.
  task automatic run_frame(input byte_q_t b);
    int i = 0;
    int len;
    logic [7:0] s;
    while (i < b.size() && b[i] != SYNC) i++;
    if (i + 1 < b.size()) begin
      len = int'(b[i+1]);
      if (len == 0 || len > 16) begin
        exp_out.push_back('{done: 1'b0, err: 1'b1});
      end else begin
        s = 8'h00;
        for (int k = 0; k < len; k++) begin
          exp_wr.push_back('{addr: 4'(k % 16), data: b[i+2+k]});
          s = s + b[i+2+k];
        end
        exp_out.push_back('{done: (b[i+2+len] == s), err: (b[i+2+len] != s)});
      end
    end
    foreach (b[k]) send_byte(b[k], 1'b1);
    drain();
  endtask

  // Monitor: pairs each mar_wr with the following ram_wr and checks frame
  // outcomes when busy falls.
  initial begin
    logic       prev_busy = 1'b0;
    logic       pend_ram  = 1'b0;
    logic [7:0] pend_data = 8'h00;
    wr_t        w;
    out_t       o;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        pend_ram  = 1'b0;
      end else begin
        if (bus_oe && !cpu_hold) check("bus_oe_without_hold", 1, 0);
        if (mar_wr && ram_wr)    check("mar_and_ram_wr", 1, 0);
        if (!bus_oe && bus_out != 8'h00) check("bus_out_idle", bus_out, 0);
        if (pend_ram) begin
          check("ram_wr_follows_mar", {ram_wr, bus_oe}, 2'b11);
          check("ram_wr_data", bus_out, pend_data);
          pend_ram = 1'b0;
        end else if (ram_wr) begin
          check("ram_wr_unpaired", 1, 0);
        end
        if (mar_wr) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_mar_wr", bus_out, 0);
            check("unexpected_write", 1, 0);
          end else begin
            w = exp_wr.pop_front();
            check("mar_addr", {bus_oe, bus_out}, {1'b1, 4'b0000, w.addr});
            pend_ram  = 1'b1;
            pend_data = w.data;
          end
        end
        if (prev_busy && !busy) begin
          if (exp_out.size() == 0) begin
            check("unexpected_frame_end", 1, 0);
          end else begin
            o = exp_out.pop_front();
            check("frame_done", done, o.done);
            check("frame_err", err, o.err);
            check("frame_rst_req", cpu_rst_req, o.done);
            check("frame_hold_released", cpu_hold, 0);
          end
        end else if (cpu_rst_req) begin
          check("stray_cpu_rst_req", 1, 0);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] all_outputs();
    return {bus_out, bus_oe, mar_wr, ram_wr, cpu_hold, cpu_rst_req, busy, done, err};
  endfunction

  initial begin
    byte_q_t fr;
    logic [7:0] s;
    int len;

    repeat (4) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_reset", all_outputs(), 0);

    // Normal load.
    run_frame('{8'hA5, 8'h03, 8'h1E, 8'h2F, 8'hE0, 8'h2D});
    check("normal_done_sticky", {done, err, busy}, 3'b100);

    // Bad checksum.
    run_frame('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31});
    check("badsum_flags", {done, err}, 2'b01);

    // Illegal lengths.
    run_frame('{8'hA5, 8'h00});
    run_frame('{8'hA5, 8'h11});
    check("badlen_flags", {done, err, cpu_hold}, 3'b010);

    // Full image with address wrap.
    fr = '{8'hA5, 8'h10};
    for (int k = 0; k < 16; k++) fr.push_back(8'(k));
    fr.push_back(8'h78);
    run_frame(fr);
    check("full_image_done", {done, err}, 2'b10);

    // Glitch, then noise byte, then a frame.
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_frame", busy, 0);
    run_frame('{8'h55, 8'hA5, 8'h01, 8'hFF, 8'hFF});
    check("noise_frame_done", {done, err}, 2'b10);

    // Framing error on a data byte.
    exp_out.push_back('{done: 1'b0, err: 1'b1});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3C, 1'b0);
    drain();
    check("framing_err_flags", {done, err, busy}, 3'b010);

    // Reset mid-frame after 3 of 5 data bytes.
    exp_wr.push_back('{addr: 4'd0, data: 8'h11});
    exp_wr.push_back('{addr: 4'd1, data: 8'h22});
    exp_wr.push_back('{addr: 4'd2, data: 8'h33});
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    check("midframe_writes_seen", exp_wr.size(), 0);
    check("midframe_busy", busy, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midframe_reset_outputs", all_outputs(), 0);
    exp_wr.delete();
    exp_out.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame('{8'hA5, 8'h02, 8'h40, 8'h41, 8'h81});
    check("after_reset_done", {done, err}, 2'b10);

    // Randomized frames, some with corrupted checksums.
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(1, 16);
      fr = '{SYNC, 8'(len)};
      s = 8'h00;
      for (int k = 0; k < len; k++) begin
        fr.push_back(8'($urandom));
        s = s + fr[k+2];
      end
      if ($urandom_range(0, 1) == 1) s = s + 8'($urandom_range(1, 255));
      fr.push_back(s);
      run_frame(fr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
